sh4_mt_wb: RTL and testbench
============================

SH4_MT_WB -- requirements
Module: sh4_mt_wb

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 mt_valid  input  1  MT-unit result valid this cycle.
REQ-004 mt_ready  output  1  stage can accept an MT result; registered, equals (count<2).
REQ-005 mt_twen  input  1  instruction updates T (CMP/TST/CLRT/SETT).
REQ-006 mt_t  input  1  new T value from MT unit.
REQ-007 mt_wen  input  1  instruction writes a general register (MOV Rm,Rn).
REQ-008 mt_wdst  input  4  destination register.
REQ-009 mt_wdata  input  32  destination data.
REQ-010 ld_valid  input  1  load-unit writeback request; always has port priority, never stalled.
REQ-011 ld_wdst / ld_wdata  input  4 / 32  load destination and data.
REQ-012 flush  input  1  discard all queued MT writebacks.
REQ-013 rf_wen / rf_wdst / rf_wdata  output  1 / 4 / 32  single register-file write port, registered.
REQ-014 sr_t  output  1  architectural T bit, registered.
REQ-015 chk_reg  input  4  scoreboard query register.
REQ-016 chk_busy  output  1  combinational: chk_reg matches a valid queued entry.

Function
REQ-017 Accept = mt_valid & mt_ready & ~flush; mt_valid while mt_ready=0 is ignored (upstream holds).
REQ-018 On accept with mt_twen=1, sr_t takes mt_t next edge; with mt_twen=0, sr_t holds.
REQ-019 On accept with mt_wen=1, {mt_wdst,mt_wdata} is enqueued into a 2-entry in-order FIFO; mt_wen=0 enqueues nothing.
REQ-020 Port arbitration each cycle: ld_valid=1 -> rf_* driven from ld_* next edge, FIFO holds; else FIFO non-empty -> head dequeued and driven next edge; else rf_wen=0 next edge.
REQ-021 Minimum MT write latency: accept in cycle N -> rf_wen=1 in cycle N+1 (visible after edge N+1) when FIFO empty and no ld_valid.
REQ-022 Simultaneous enqueue and dequeue: count unchanged, order preserved; enqueue at count=2 impossible (mt_ready=0).
REQ-023 FIFO pointers wrap modulo 2; count range 0..2.
REQ-024 flush: count and pointers cleared next edge; a dequeue in the flush cycle is also suppressed; ld_valid write unaffected; sr_t unaffected.
REQ-025 Two queued entries to same register commit in program order; chk_busy=1 while either is queued.
REQ-026 chk_busy excludes the entry being written this cycle's rf_* output (already committed).

Reset
REQ-027 On rst_n low: count=0, pointers=0, rf_wen=0, rf_wdst=0, rf_wdata=0, sr_t=0, mt_ready=0; mt_ready becomes 1 on first edge after release.
REQ-028 Reset mid-operation discards queued entries without writing them.

Configuration
REQ-029 SH4_MT_WB_FWD_EN defined: add outputs fwd_hit (1) and fwd_data (32) giving youngest queued data for chk_reg, combinational.
REQ-030 SH4_MT_WB_FWD_EN undefined: ports fwd_hit/fwd_data absent; only chk_busy provided; no other behaviour changes.

Structure
REQ-031 Shared package holds WB_QDEPTH=2, the queue-entry typedef {wdst[3:0], wdata[31:0]}, and the register-index width constant.
REQ-032 One sub-module sh4_wb_fifo (2-entry, count, pointers, scoreboard match); arbitration and sr_t in the top.

Verification
REQ-033 Reset release, mt_valid=1 mt_wen=1 wdst=5 wdata=0x12345678 -> next cycle rf_wen=1 rf_wdst=5 rf_wdata=0x12345678.
REQ-034 mt_twen=1 mt_t=1 mt_wen=0 -> sr_t=1 next cycle, rf_wen=0, FIFO count stays 0.
REQ-035 ld_valid held 3 cycles while two MT writes (R1=0xA, R2=0xB) accepted -> mt_ready=0 after second, rf shows load x3 then R1=0xA, R2=0xB; chk_reg=2 busy until R2 written.
REQ-036 Two queued entries then flush=1 -> no MT writes appear, count=0, sr_t unchanged, mt_ready=1 next cycle.
REQ-037 rst_n pulsed low with 2 entries queued -> rf_wen=0, sr_t=0 immediately (async), no queued write after release.
REQ-038 With SH4_MT_WB_FWD_EN: queue R3=0x1 then R3=0x2 under ld_valid stall, chk_reg=3 -> fwd_hit=1 fwd_data=0x2.

Source files
------------

// File: rtl/sh4_mt_wb_pkg.sv
// Shared types and sizing for the SH4 MT-unit writeback stage.
// Queue depth, register-index width and the queued writeback entry layout.
package sh4_mt_wb_pkg;

    localparam int WB_QDEPTH = 2;
    localparam int REG_IDX_W = 4;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = $clog2(WB_QDEPTH + 1);

    typedef struct packed {
        logic [REG_IDX_W-1:0] wdst;
        logic [DATA_W-1:0]    wdata;
    } wb_entry_t;

endpackage

// File: rtl/sh4_wb_fifo.sv
// 2-entry in-order writeback queue with register scoreboard match.
// SH4_MT_WB_FWD_EN adds youngest-entry forwarding outputs.
module sh4_wb_fifo
    import sh4_mt_wb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 enq,
    input  wb_entry_t            enq_entry,
    input  logic                 deq,
    output wb_entry_t            head,
    output logic [CNT_W-1:0]     count,
    output logic [CNT_W-1:0]     count_nxt,
    input  logic [REG_IDX_W-1:0] chk_reg,
    output logic                 chk_busy
`ifdef SH4_MT_WB_FWD_EN
    ,
    output logic                 fwd_hit,
    output logic [DATA_W-1:0]    fwd_data
`endif
);

    wb_entry_t            mem [WB_QDEPTH];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [WB_QDEPTH-1:0] q_vld;
    logic [WB_QDEPTH-1:0] hit;

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (enq && !deq)
            count_nxt = count + CNT_W'(1);
        else if (!enq && deq)
            count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            count <= count_nxt;
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (enq) wr_ptr <= ~wr_ptr;
                if (deq) rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enq && !flush)
            mem[wr_ptr] <= enq_entry;
    end

    assign head = mem[rd_ptr];

    always_comb begin
        q_vld = '0;
        hit   = '0;
        if (count != '0)
            q_vld[rd_ptr] = 1'b1;
        if (count == CNT_W'(WB_QDEPTH))
            q_vld[~rd_ptr] = 1'b1;
        for (int i = 0; i < WB_QDEPTH; i++)
            hit[i] = q_vld[i] && (mem[i].wdst == chk_reg);
    end

    assign chk_busy = |hit;

`ifdef SH4_MT_WB_FWD_EN
    logic yng;

    // The most recent enqueue sits just behind the write pointer.
    assign yng      = ~wr_ptr;
    assign fwd_hit  = |hit;
    assign fwd_data = hit[yng] ? mem[yng].wdata : mem[~yng].wdata;
`endif

endmodule

// File: rtl/sh4_mt_wb.sv
// SH4 MT-unit writeback stage: T-bit update, queued MT register writes, load-priority port.
// Define SH4_MT_WB_FWD_EN to expose fwd_hit/fwd_data forwarding outputs.
module sh4_mt_wb
    import sh4_mt_wb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mt_valid,
    output logic                 mt_ready,
    input  logic                 mt_twen,
    input  logic                 mt_t,
    input  logic                 mt_wen,
    input  logic [REG_IDX_W-1:0] mt_wdst,
    input  logic [DATA_W-1:0]    mt_wdata,
    input  logic                 ld_valid,
    input  logic [REG_IDX_W-1:0] ld_wdst,
    input  logic [DATA_W-1:0]    ld_wdata,
    input  logic                 flush,
    output logic                 rf_wen,
    output logic [REG_IDX_W-1:0] rf_wdst,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 sr_t,
    input  logic [REG_IDX_W-1:0] chk_reg,
    output logic                 chk_busy
`ifdef SH4_MT_WB_FWD_EN
    ,
    output logic                 fwd_hit,
    output logic [DATA_W-1:0]    fwd_data
`endif
);

    logic             accept;
    logic             fifo_empty;
    logic             bypass;
    logic             enq;
    logic             deq;
    wb_entry_t        mt_entry;
    wb_entry_t        head;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    assign accept     = mt_valid && mt_ready && !flush;
    assign fifo_empty = (count == '0);
    // An MT write with nothing ahead of it skips the queue for one-edge latency.
    assign bypass     = accept && mt_wen && fifo_empty && !ld_valid;
    assign enq        = accept && mt_wen && !bypass;
    assign deq        = !ld_valid && !fifo_empty && !flush;
    assign mt_entry   = '{wdst: mt_wdst, wdata: mt_wdata};

    sh4_wb_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .enq       (enq),
        .enq_entry (mt_entry),
        .deq       (deq),
        .head      (head),
        .count     (count),
        .count_nxt (count_nxt),
        .chk_reg   (chk_reg),
        .chk_busy  (chk_busy)
`ifdef SH4_MT_WB_FWD_EN
        ,
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt_ready <= 1'b0;
            sr_t     <= 1'b0;
            rf_wen   <= 1'b0;
            rf_wdst  <= '0;
            rf_wdata <= '0;
        end else begin
            mt_ready <= (count_nxt < CNT_W'(WB_QDEPTH));
            if (accept && mt_twen)
                sr_t <= mt_t;
            rf_wen <= ld_valid || deq || bypass;
            // Load always owns the port; the queue head waits behind it.
            if (ld_valid) begin
                rf_wdst  <= ld_wdst;
                rf_wdata <= ld_wdata;
            end else if (deq) begin
                rf_wdst  <= head.wdst;
                rf_wdata <= head.wdata;
            end else if (bypass) begin
                rf_wdst  <= mt_wdst;
                rf_wdata <= mt_wdata;
            end
        end
    end

endmodule

// File: tb/tb_sh4_mt_wb.sv
// Directed bench for sh4_mt_wb: expected register-file writes queued in order, checked as they appear.
module tb_sh4_mt_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mt_valid, mt_ready, mt_twen, mt_t, mt_wen;
    logic [3:0]  mt_wdst;
    logic [31:0] mt_wdata;
    logic        ld_valid;
    logic [3:0]  ld_wdst;
    logic [31:0] ld_wdata;
    logic        flush;
    logic        rf_wen;
    logic [3:0]  rf_wdst;
    logic [31:0] rf_wdata;
    logic        sr_t;
    logic [3:0]  chk_reg;
    logic        chk_busy;
`ifdef SH4_MT_WB_FWD_EN
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [35:0] exp_q [$];

    always #5 clk = ~clk;

    sh4_mt_wb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mt_valid (mt_valid),
        .mt_ready (mt_ready),
        .mt_twen  (mt_twen),
        .mt_t     (mt_t),
        .mt_wen   (mt_wen),
        .mt_wdst  (mt_wdst),
        .mt_wdata (mt_wdata),
        .ld_valid (ld_valid),
        .ld_wdst  (ld_wdst),
        .ld_wdata (ld_wdata),
        .flush    (flush),
        .rf_wen   (rf_wen),
        .rf_wdst  (rf_wdst),
        .rf_wdata (rf_wdata),
        .sr_t     (sr_t),
        .chk_reg  (chk_reg),
        .chk_busy (chk_busy)
`ifdef SH4_MT_WB_FWD_EN
        ,
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mt_valid = 1'b0; mt_twen = 1'b0; mt_t = 1'b0; mt_wen = 1'b0;
        mt_wdst = '0; mt_wdata = '0;
        ld_valid = 1'b0; ld_wdst = '0; ld_wdata = '0;
        flush = 1'b0;
    endtask

    task automatic drive_mt(input logic [3:0] dst, input logic [31:0] data);
        mt_valid = 1'b1; mt_wen = 1'b1; mt_twen = 1'b0;
        mt_wdst = dst; mt_wdata = data;
    endtask

    task automatic drive_ld(input logic [3:0] dst, input logic [31:0] data);
        ld_valid = 1'b1; ld_wdst = dst; ld_wdata = data;
    endtask

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_wen === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL sb_unexpected: observed write r%0d=%0h expected none", rf_wdst, rf_wdata);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                assert ({rf_wdst, rf_wdata} === e) else begin
                    n_fail++;
                    $error("FAIL sb_write: observed %0h expected %0h", {rf_wdst, rf_wdata}, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        chk_reg = '0;
        idle_inputs();
        #3;
        check("rst_rf_wen",   {31'd0, rf_wen},   32'd0);
        check("rst_rf_wdst",  {28'd0, rf_wdst},  32'd0);
        check("rst_rf_wdata", rf_wdata,          32'd0);
        check("rst_sr_t",     {31'd0, sr_t},     32'd0);
        check("rst_mt_ready", {31'd0, mt_ready}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", {31'd0, mt_ready}, 32'd1);

        // Single MT write with empty queue: visible one edge later.
        exp_q.push_back({4'd5, 32'h1234_5678});
        drive_mt(4'd5, 32'h1234_5678);
        tick();
        idle_inputs();
        check("lat_rf_wen",   {31'd0, rf_wen}, 32'd1);
        check("lat_rf_wdst",  {28'd0, rf_wdst}, 32'd5);
        check("lat_rf_wdata", rf_wdata, 32'h1234_5678);
        tick();
        check("lat_rf_idle", {31'd0, rf_wen}, 32'd0);

        // T-bit only update.
        mt_valid = 1'b1; mt_twen = 1'b1; mt_t = 1'b1; mt_wen = 1'b0;
        tick();
        idle_inputs();
        check("t_set_sr_t",   {31'd0, sr_t}, 32'd1);
        check("t_set_rf_wen", {31'd0, rf_wen}, 32'd0);
        check("t_set_count",  {30'd0, dut.u_fifo.count}, 32'd0);
        mt_valid = 1'b1; mt_twen = 1'b0; mt_t = 1'b0;
        tick();
        idle_inputs();
        check("t_hold_sr_t", {31'd0, sr_t}, 32'd1);

        // Load stall while two MT writes queue up.
        exp_q.push_back({4'd7, 32'h100});
        exp_q.push_back({4'd7, 32'h101});
        exp_q.push_back({4'd7, 32'h102});
        exp_q.push_back({4'd1, 32'hA});
        exp_q.push_back({4'd2, 32'hB});
        chk_reg = 4'd2;
        drive_ld(4'd7, 32'h100); drive_mt(4'd1, 32'hA);
        tick();
        check("stall_busy_a",  {31'd0, chk_busy}, 32'd0);
        check("stall_ready_a", {31'd0, mt_ready}, 32'd1);
        drive_ld(4'd7, 32'h101); drive_mt(4'd2, 32'hB);
        tick();
        check("stall_ready_b", {31'd0, mt_ready}, 32'd0);
        check("stall_busy_b",  {31'd0, chk_busy}, 32'd1);
        drive_ld(4'd7, 32'h102); drive_mt(4'd9, 32'hDEAD);
        tick();
        idle_inputs();
        check("stall_ready_c", {31'd0, mt_ready}, 32'd0);
        check("stall_busy_c",  {31'd0, chk_busy}, 32'd1);
        tick();
        check("drain_r1_wdst", {28'd0, rf_wdst}, 32'd1);
        check("drain_busy_r1", {31'd0, chk_busy}, 32'd1);
        check("drain_ready",   {31'd0, mt_ready}, 32'd1);
        tick();
        check("drain_r2_wdst", {28'd0, rf_wdst}, 32'd2);
        check("drain_busy_r2", {31'd0, chk_busy}, 32'd0);
        tick();
        check("drain_idle", {31'd0, rf_wen}, 32'd0);

        // Two writes to the same register commit oldest first.
        exp_q.push_back({4'd7, 32'h400});
        exp_q.push_back({4'd7, 32'h401});
        exp_q.push_back({4'd3, 32'h1});
        exp_q.push_back({4'd3, 32'h2});
        chk_reg = 4'd3;
        drive_ld(4'd7, 32'h400); drive_mt(4'd3, 32'h1);
        tick();
        drive_ld(4'd7, 32'h401); drive_mt(4'd3, 32'h2);
        tick();
        idle_inputs();
        check("same_busy_2", {31'd0, chk_busy}, 32'd1);
`ifdef SH4_MT_WB_FWD_EN
        check("fwd_hit",  {31'd0, fwd_hit}, 32'd1);
        check("fwd_data", fwd_data, 32'h2);
`endif
        tick();
        check("same_first",  rf_wdata, 32'h1);
        check("same_busy_1", {31'd0, chk_busy}, 32'd1);
`ifdef SH4_MT_WB_FWD_EN
        check("fwd_data_1", fwd_data, 32'h2);
`endif
        tick();
        check("same_second", rf_wdata, 32'h2);
        check("same_busy_0", {31'd0, chk_busy}, 32'd0);
        tick();

        // Flush with two queued entries; the concurrent load still writes.
        exp_q.push_back({4'd7, 32'h500});
        exp_q.push_back({4'd7, 32'h501});
        exp_q.push_back({4'd7, 32'h502});
        chk_reg = 4'd4;
        drive_ld(4'd7, 32'h500); drive_mt(4'd4, 32'h44);
        tick();
        drive_ld(4'd7, 32'h501); drive_mt(4'd6, 32'h66);
        tick();
        idle_inputs();
        check("pre_flush_busy", {31'd0, chk_busy}, 32'd1);
        flush = 1'b1;
        drive_ld(4'd7, 32'h502);
        tick();
        idle_inputs();
        check("flush_ld_wen",  {31'd0, rf_wen}, 32'd1);
        check("flush_ld_data", rf_wdata, 32'h502);
        check("flush_ready",   {31'd0, mt_ready}, 32'd1);
        check("flush_count",   {30'd0, dut.u_fifo.count}, 32'd0);
        check("flush_busy",    {31'd0, chk_busy}, 32'd0);
        check("flush_sr_t",    {31'd0, sr_t}, 32'd1);
        // Flush also blocks an otherwise acceptable MT result.
        flush = 1'b1;
        drive_mt(4'd12, 32'hC0DE);
        mt_twen = 1'b1; mt_t = 1'b0;
        tick();
        idle_inputs();
        check("flush_blk_wen",  {31'd0, rf_wen}, 32'd0);
        check("flush_blk_sr_t", {31'd0, sr_t}, 32'd1);
        tick();
        check("flush_no_write", {31'd0, rf_wen}, 32'd0);

        // Asynchronous reset with two entries queued.
        exp_q.push_back({4'd7, 32'h300});
        exp_q.push_back({4'd7, 32'h301});
        chk_reg = 4'd8;
        drive_ld(4'd7, 32'h300); drive_mt(4'd8, 32'h88);
        tick();
        drive_ld(4'd7, 32'h301); drive_mt(4'd9, 32'h99);
        tick();
        idle_inputs();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_rf_wen",   {31'd0, rf_wen}, 32'd0);
        check("arst_sr_t",     {31'd0, sr_t}, 32'd0);
        check("arst_mt_ready", {31'd0, mt_ready}, 32'd0);
        check("arst_busy",     {31'd0, chk_busy}, 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        check("arst_no_write", {31'd0, rf_wen}, 32'd0);
        check("arst_ready",    {31'd0, mt_ready}, 32'd1);
        check("sb_drained",    exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
